// File: rtl/gate_bl_pkg.sv
// Shared types and the per-bit gate function for the gate_bl_pipe block.
// The function works on a single bit position so the top can replicate it
// across any operand WIDTH without a width-fixed package function.
package gate_bl_pkg;

  localparam int FN_W = 3;

  typedef enum logic [FN_W-1:0] {
    FN_AND     = 3'b000,
    FN_OR      = 3'b001,
    FN_NOTB    = 3'b010,
    FN_NAND    = 3'b011,
    FN_NOR     = 3'b100,
    FN_XOR     = 3'b101,
    FN_XNOR    = 3'b110,
    FN_ILLEGAL = 3'b111
  } fn_e;

  // Returns {err, y} for one bit position; the illegal code yields y=0, err=1.
  function automatic logic [1:0] gate_eval(input logic [FN_W-1:0] fn,
                                           input logic a,
                                           input logic b);
    logic y;
    logic err;
    y   = 1'b0;
    err = 1'b0;
    case (fn_e'(fn))
      FN_AND:     y = a & b;
      FN_OR:      y = a | b;
      FN_NOTB:    y = ~b;
      FN_NAND:    y = ~(a & b);
      FN_NOR:     y = ~(a | b);
      FN_XOR:     y = a ^ b;
      FN_XNOR:    y = ~(a ^ b);
      FN_ILLEGAL: err = 1'b1;
      default:    err = 1'b1;
    endcase
    return {err, y};
  endfunction

endpackage

// File: rtl/gate_bl_buf2.sv
// Generic 2-entry valid/ready FIFO. in_ready depends only on the occupancy
// register, so there is no combinational path from out_ready to in_ready.
// out_data shows the head entry and is forced to zero when empty.
module gate_bl_buf2 #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state: advance pointers on push/pop, track occupancy, write tail slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    for (int i = 0; i < 2; i++) begin
      mem_d[i] = (push && (wr_ptr_q == 1'(i))) ? in_data : mem_q[i];
    end
  end

  // State registers; storage needs no reset because the output is gated by cnt.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_bl_pipe.sv
// Handshaked bitwise gate unit: evaluates fn(a,b) on the push path and holds
// results in a 2-entry FIFO so backpressure in either direction loses nothing.
// Optional feature macro: OP_COUNT_EN adds the op_count port (accepted-op
// counter, CNT_W bits, wraps). Without it CNT_W is unused.
module gate_bl_pipe
  import gate_bl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [FN_W-1:0]  fn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
`ifdef OP_COUNT_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  logic [WIDTH-1:0] y_bits;
  logic [WIDTH-1:0] err_bits;
  logic [WIDTH:0]   push_data;
  logic [WIDTH:0]   head_data;
  logic             push;

  // Replicate the single-bit gate across the operand width.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [1:0] res;
    assign res          = gate_eval(fn, a[gi], b[gi]);
    assign err_bits[gi] = res[1];
    assign y_bits[gi]   = res[0];
  end

  assign push_data = {|err_bits, y_bits};
  assign push      = in_valid && in_ready;

  gate_bl_buf2 #(
    .DW(WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_data)
  );

  assign err = head_data[WIDTH];
  assign y   = head_data[WIDTH-1:0];

`ifdef OP_COUNT_EN
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Count every accepted transfer, illegal fn included; wraps naturally.
  always_comb begin
    op_count_d = push ? op_count_q + CNT_W'(1) : op_count_q;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  logic unused_cnt_w;
  logic unused_push;
  assign unused_cnt_w = (CNT_W > 0);
  assign unused_push  = push;
`endif

endmodule

// File: tb/tb_gate_bl_pipe.sv
// Directed and randomised self-checking bench for gate_bl_pipe (WIDTH=8, CNT_W=4).
module tb_gate_bl_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] fn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       err;
`ifdef OP_COUNT_EN
  logic [3:0] op_count;
`endif

  int tests_run;
  int tests_failed;

  logic [7:0] exp_tbl [7] = '{8'h30, 8'hFC, 8'hC3, 8'hCF, 8'h03, 8'hCC, 8'h33};

  gate_bl_pipe #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .fn        (fn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
`ifdef OP_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent word-level reference for {err, y}.
  function automatic logic [8:0] ref_gate(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
    case (f)
      3'd0:    return {1'b0, x & z};
      3'd1:    return {1'b0, x | z};
      3'd2:    return {1'b0, ~z};
      3'd3:    return {1'b0, ~(x & z)};
      3'd4:    return {1'b0, ~(x | z)};
      3'd5:    return {1'b0, x ^ z};
      3'd6:    return {1'b0, ~(x ^ z)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if ({err, y} !== 9'h000) begin tests_failed++; $display("FAIL reset_y_err: got %h expected 000", {err, y}); end
`ifdef OP_COUNT_EN
    tests_run++;
    if (op_count !== 4'd0) begin tests_failed++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`endif
    $display("[TB] reset released");
  endtask

  task automatic test_functions();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 8'hF0;
    b = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      fn = 3'(i);
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL fn%0d_in_ready: got %b expected 1", i, in_ready); end
      step();
      $display("[TB] fn=%0d a=%h b=%h -> y=%h err=%b valid=%b", i, a, b, y, err, out_valid);
      tests_run++;
      if ({out_valid, err, y} !== {1'b1, 1'b0, exp_tbl[i]}) begin
        tests_failed++;
        $display("FAIL fn%0d_result: got v=%b e=%b y=%h expected v=1 e=0 y=%h", i, out_valid, err, y, exp_tbl[i]);
      end
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fn_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fn = 3'b111;
    a  = 8'hFF;
    b  = 8'hFF;
    step();
    in_valid = 1'b0;
    $display("[TB] fn=7 a=FF b=FF -> y=%h err=%b valid=%b", y, err, out_valid);
    tests_run++;
    if ({out_valid, err, y} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL illegal_result: got v=%b e=%b y=%h expected v=1 e=1 y=00", out_valid, err, y);
    end
    step();
    tests_run++;
    if ({out_valid, err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL illegal_delivered: got v=%b e=%b expected v=0 e=0", out_valid, err);
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fn = 3'd0;
    b  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      a = 8'(8'h11 * (i + 1));
      tests_run++;
      if (in_ready !== exp_rdy[i]) begin tests_failed++; $display("FAIL bp_in_ready%0d: got %b expected %b", i, in_ready, exp_rdy[i]); end
      if (in_ready === 1'b1) acc++;
      step();
      $display("[TB] offer a=%h in_ready_was=%b head=%h", a, exp_rdy[i], y);
      tests_run++;
      if (y !== 8'h11) begin tests_failed++; $display("FAIL bp_head_stable%0d: got %h expected 11", i, y); end
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc !== 2) begin tests_failed++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
    out_ready = 1'b1;
    step();
    $display("[TB] pop -> head=%h in_ready=%b", y, in_ready);
    tests_run++;
    if ({out_valid, y, in_ready} !== {1'b1, 8'h22, 1'b1}) begin
      tests_failed++;
      $display("FAIL bp_pop1: got v=%b y=%h rdy=%b expected v=1 y=22 rdy=1", out_valid, y, in_ready);
    end
    step();
    tests_run++;
    if ({out_valid, y} !== {1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL bp_pop2: got v=%b y=%h expected v=0 y=00", out_valid, y);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fn = 3'd0;
    b  = 8'hFF;
    a  = 8'hAA;
    step();
    a  = 8'hBB;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 8'hAA}) begin
      tests_failed++;
      $display("FAIL rm_full: got v=%b rdy=%b y=%h expected v=1 rdy=0 y=AA", out_valid, in_ready, y);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    fn = 3'b111;
    a  = 8'hCC;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    $display("[TB] mid-stream reset -> v=%b rdy=%b y=%h err=%b", out_valid, in_ready, y, err);
    tests_run++;
    if ({out_valid, in_ready, err, y} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL rm_after: got v=%b rdy=%b e=%b y=%h expected v=0 rdy=1 e=0 y=00", out_valid, in_ready, err, y);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_ghost%0d: got v=%b y=%h expected v=0", i, out_valid, y); end
    end
  endtask

`ifdef OP_COUNT_EN
  task automatic test_op_count();
    int acc = 0;
    int cyc = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fn = 3'b111;
    a  = 8'h00;
    b  = 8'h00;
    repeat (4) step();
    $display("[TB] 4 offers under stall -> op_count=%0d", op_count);
    tests_run++;
    if (op_count !== 4'd2) begin tests_failed++; $display("FAIL cnt_stall: got %0d expected 2", op_count); end
    out_ready = 1'b1;
    fn = 3'd1;
    while (acc < 15 && cyc < 100) begin
      if (in_ready === 1'b1) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc !== 15) begin tests_failed++; $display("FAIL cnt_accept_timeout: got %0d expected 15", acc); end
    $display("[TB] 17 accepted -> op_count=%0d", op_count);
    tests_run++;
    if (op_count !== 4'd1) begin tests_failed++; $display("FAIL cnt_wrap: got %0d expected 1", op_count); end
    repeat (3) step();
  endtask
`endif

  task automatic test_random();
    logic [8:0] q [$];
    logic [8:0] exp_v;
    int sent = 0;
    int got = 0;
    int cycles = 0;
    logic do_push;
    logic do_pop;
    rst = 1'b1;
    step();
    rst = 1'b0;
    while ((sent < 1000 || got < 1000) && cycles < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      fn = 3'($urandom_range(0, 7));
      tests_run++;
      if (out_valid !== (q.size() != 0)) begin
        tests_failed++;
        $display("FAIL rnd_valid: got %b expected %b at cycle %0d", out_valid, (q.size() != 0), cycles);
      end
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_spurious: got y=%h err=%b expected no output", y, err);
        end else begin
          exp_v = q.pop_front();
          $display("[TB] rnd pop %0d y=%h err=%b", got, y, err);
          if ({err, y} !== exp_v) begin
            tests_failed++;
            $display("FAIL rnd_data%0d: got %h expected %h", got, {err, y}, exp_v);
          end
        end
        got++;
      end
      if (do_push) begin
        q.push_back(ref_gate(fn, a, b));
        sent++;
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (got !== 1000 || q.size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_count: got %0d delivered, %0d left, expected 1000 and 0", got, q.size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a  = 8'h00;
    b  = 8'h00;
    fn = 3'd0;
    test_reset();
    test_functions();
    test_illegal();
    test_backpressure();
    test_reset_mid();
`ifdef OP_COUNT_EN
    test_op_count();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
